// File: rtl/pcpu_pkg.sv
// Shared definitions for the pcpu instruction-memory responder: opcodes, NOP word, FSM states.
package pcpu_pkg;

    localparam logic [4:0]  OP_NOP   = 5'b00000;
    localparam logic [4:0]  OP_HALT  = 5'b00001;
    localparam logic [15:0] NOP_WORD = 16'h0000;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_START   = 2'd1,
        ST_RUN     = 2'd2,
        ST_HALTED  = 2'd3
    } imem_state_e;

endpackage

// File: rtl/pcpu_imem_if.sv
// Load stream and instruction-fetch bus between a program source/CPU and pcpu_imem.
interface pcpu_imem_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          ld_valid;
    logic          ld_ready;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_data;

    modport master (
        output ld_valid, ld_data, ld_last, i_addr,
        input  ld_ready, i_data
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, i_addr,
        output ld_ready, i_data
    );
endinterface

// File: rtl/pcpu_imem_ram.sv
// Program store: DEPTH x DW array, synchronous write, asynchronous read, no reset.
module pcpu_imem_ram #(
    parameter int AW    = 8,
    parameter int DW    = 16,
    parameter int DEPTH = 256
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/pcpu_imem.sv
// Instruction-memory responder for pcpu: load stream fills the store, then starts the CPU.
// Optional HALT detection and reload-from-halt enabled by defining PCPU_IMEM_HALT_DET_EN.
module pcpu_imem
    import pcpu_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DW    = 16,
    parameter int DEPTH = 256
) (
    input  logic          clock,
    input  logic          reset,
    pcpu_imem_if.slave    bus,
    output logic          cpu_enable,
    output logic          cpu_start,
    output logic          running,
    output logic          halted,
    output logic [AW:0]   ld_count
);
    localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);

    imem_state_e   state_q, state_d;
    logic [AW:0]   ld_count_q, ld_count_d;
    logic          xfer;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] rd_word;
    logic          serving;

    pcpu_imem_ram #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_ram (
        .clock (clock),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (bus.ld_data),
        .raddr (bus.i_addr),
        .rdata (rd_word)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_LOAD;
            ld_count_q <= '0;
        end else begin
            state_q    <= state_d;
            ld_count_q <= ld_count_d;
        end
    end

    // Output decode from registered state only
    always_comb begin
        bus.ld_ready = (state_q == ST_LOAD);
        halted       = 1'b0;
        serving      = (state_q == ST_RUN);
`ifdef PCPU_IMEM_HALT_DET_EN
        if (state_q == ST_HALTED) begin
            bus.ld_ready = 1'b1;
            halted       = 1'b1;
            serving      = 1'b1;
        end
`endif
        cpu_enable = (state_q != ST_LOAD);
        cpu_start  = (state_q == ST_START);
        running    = (state_q != ST_LOAD);
    end

    assign xfer     = bus.ld_valid && bus.ld_ready;
    assign ld_count = ld_count_q;

    // Words at or past ld_count read as NOP so stale RAM never leaks out
    always_comb begin
        bus.i_data = NOP_WORD;
        if (serving && ({1'b0, bus.i_addr} < ld_count_q)) bus.i_data = rd_word;
    end

    always_comb begin
        state_d    = state_q;
        ld_count_d = ld_count_q;
        wr_en      = xfer;
        wr_addr    = ld_count_q[AW-1:0];
        case (state_q)
            ST_LOAD: begin
                if (xfer) begin
                    ld_count_d = ld_count_q + 1'b1;
                    if (bus.ld_last || (ld_count_q == LAST_CNT)) state_d = ST_START;
                end
            end
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
`ifdef PCPU_IMEM_HALT_DET_EN
                if (bus.i_data[DW-1 -: 5] == OP_HALT) state_d = ST_HALTED;
`endif
            end
            default: begin
`ifdef PCPU_IMEM_HALT_DET_EN
                // Reload restarts the program at address 0 regardless of the old count
                if (xfer) begin
                    wr_addr    = '0;
                    ld_count_d = (AW+1)'(1);
                    state_d    = bus.ld_last ? ST_START : ST_LOAD;
                end
`else
                state_d = ST_LOAD;
`endif
            end
        endcase
    end
endmodule

// File: doc/pcpu_imem.md
# pcpu_imem

Instruction-memory responder for the 16-bit pipeline processor `pcpu`. It is the far end of the CPU's instruction-fetch interface: it answers `i_addr` with `i_data` from a 256×16 program store. A valid/ready load stream fills the store, then the block pulses the CPU start sequence. It replaces hand-driven instruction feeding in benches and system tops.

## Interface
Parameters:
- `AW`, 8: fetch address width.
- `DW`, 16: instruction width.
- `DEPTH`, 256: number of words, equal to 2^AW.

Ports:
- `clock`, in, 1: single clock; all state changes on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `ld_valid`, in, 1: load word present.
- `ld_ready`, out, 1: block accepts a load word.
- `ld_data`, in, DW: instruction word to store.
- `ld_last`, in, 1: marks the final word of the program; qualified by a transfer.
- `i_addr`, in, AW: CPU fetch address.
- `i_data`, out, DW: instruction returned to the CPU.
- `cpu_enable`, out, 1: drives the CPU `enable` input.
- `cpu_start`, out, 1: one-cycle pulse on the CPU `start` input.
- `running`, out, 1: high in START, RUN and HALTED.
- `halted`, out, 1: a HALT opcode has been served. Only driven when `PCPU_IMEM_HALT_DET_EN` is defined; otherwise tied to 0.
- `ld_count`, out, AW+1: number of words loaded, 0..256.

## Operation
- A transfer occurs on a cycle where `ld_valid && ld_ready`. On a transfer, `mem[ld_count[AW-1:0]] <= ld_data` and `ld_count` increments.
- The FSM has four states: LOAD, START, RUN and HALTED.
- **LOAD**
  - `ld_ready=1`, `cpu_enable=0`.
  - On a transfer with `ld_last=1`, or the transfer of the 256th word, go to START.
- **START**
  - `cpu_enable=1`, `cpu_start=1`, `ld_ready=0`.
  - Always go to RUN next cycle.
- **RUN**
  - `cpu_enable=1`, `ld_ready=0`.
  - `i_data = (i_addr < ld_count) ? mem[i_addr] : 16'h0000` (NOP).
  - With halt detection, if `i_data[15:11] == 5'b00001` (HALT), go to HALTED.
- **HALTED**
  - `halted=1`, `cpu_enable=1`, and fetch is served as in RUN.
  - `ld_ready=1`. A transfer here clears `ld_count` to 0, writes the word at address 0 (`ld_count` becomes 1), drops `cpu_enable` and goes to LOAD. If that word carries `ld_last`, go directly to START.
- Fetch outside RUN and HALTED: `i_data = 16'h0000`.
- Addresses at or beyond `ld_count` read as NOP. Stale RAM contents are never exposed.
- `ld_last` on a non-transfer cycle is ignored.
- RAM contents are not cleared by reset. Reset only clears `ld_count`, which makes them unreadable.

## Timing
- Reset values: state=LOAD, `ld_ready=1`, `ld_count=0`, `i_data=0`, `cpu_enable=0`, `cpu_start=0`, `running=0`, `halted=0`.
- Reset asserted mid-load or mid-run returns to these values on the next edge; reset wins over a simultaneous transfer.
- `ld_ready`, `cpu_enable`, `cpu_start`, `running` and `halted` decode from registered state only.
- `i_data` is a combinational read of `i_addr`, giving zero-cycle fetch latency as the CPU requires.
- Final transfer at edge N gives `cpu_start=1` for exactly the cycle N→N+1, and `cpu_enable=1` from N onward.
- HALT presented on `i_data` in cycle K gives `halted=1` from edge K+1.
- Write and read of the same address never coincide, because loading and fetching are in disjoint states. Only the RUN→HALTED overlap exists, and there the write goes to address 0 with the same-cycle read returning the old word.

## Configuration
- Macro: `PCPU_IMEM_HALT_DET_EN`.
- Defined: HALTED state is present, `halted` is functional, and reload from HALTED is supported.
- Undefined: HALTED is not built, `halted=0`, and RUN persists until `reset`. Reloading requires reset.

## Structure
- Shared package `pcpu_pkg` holds:
  - opcode constants `OP_NOP=5'b00000` and `OP_HALT=5'b00001`;
  - the `NOP_WORD` constant;
  - the FSM state enum.
- Sub-module `pcpu_imem_ram` is a DEPTH×DW array with a synchronous write port and an asynchronous read port. The top contains the FSM, counter and NOP masking.

## Test plan
- Load 16'h4924 (ADDI gr1,2,4), 16'h4A11 (ADDI gr2,1,1), 16'h0800 (HALT) back-to-back, with `ld_last` on the third word. Required response: `ld_count=3`; `ld_ready` drops the cycle after the third transfer; `cpu_start` is high for exactly one cycle; `cpu_enable` stays high.
- In RUN:
  - `i_addr=1` gives `i_data=16'h4A11` in the same cycle.
  - `i_addr=3` gives 16'h0000.
  - `i_addr=255` gives 16'h0000.
- In RUN, `i_addr=2` gives `halted=1` on the next edge. Built without the macro, `halted` stays 0 and the state stays RUN.
- Drive 256 words with `ld_valid` gaps (idle cycles) and no `ld_last`. Required response: no writes on idle cycles; START is entered after the 256th transfer; `ld_count=256`; `ld_ready=0`.
- Assert `reset` after 2 words are loaded. Required response: `ld_count=0`, `ld_ready=1`, `i_data=0`, `cpu_enable=0`. A subsequent fetch at `i_addr=0` after reloading one word with `ld_last` returns only the new word.
- From HALTED, send 16'h0800 with `ld_last`. Required response: START, then RUN with `ld_count=1`, `halted=0`, and one new `cpu_start` pulse.
